// File: rtl/addr_decoder_cfg_loader_pkg.sv
// rtl/addr_decoder_cfg_loader_pkg.sv - shared state type, sync byte and error codes for the config frame loader
package addr_decoder_cfg_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        LEN,
        DATA,
        CHK,
        REPLAY
    } state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_LEN     = 3'd1;
    localparam logic [2:0] ERR_RANGE   = 3'd2;
    localparam logic [2:0] ERR_CHK     = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT = 3'd4;

    function automatic int unsigned idx_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/loader_frame_buf.sv
// rtl/loader_frame_buf.sv - MAX_LEN x 8 frame buffer, one write port and one registered read port
module loader_frame_buf
    import addr_decoder_cfg_loader_pkg::*;
#(
    parameter int unsigned MAX_LEN = 32,
    parameter int unsigned IW      = idx_width(MAX_LEN)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [IW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [IW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [MAX_LEN];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/addr_decoder_cfg_loader.sv
// rtl/addr_decoder_cfg_loader.sv - buffers and validates config frames, then replays them as byte writes
// Optional inter-byte timeout enabled by ADDR_DECODER_CFG_LOADER_TIMEOUT_EN.
module addr_decoder_cfg_loader
    import addr_decoder_cfg_loader_pkg::*;
#(
    parameter int unsigned MAX_LEN     = 32,
    parameter int unsigned CFG_SIZE    = 160,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic       cfg_clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       cfg_we,
    output logic [7:0] cfg_addr,
    output logic [7:0] cfg_wdata,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [2:0] err_code
);

    localparam int unsigned IW      = idx_width(MAX_LEN);
    localparam logic [7:0]  LEN_MAX = 8'(MAX_LEN);
    localparam logic [8:0]  CFG_LIM = 9'(CFG_SIZE);

    state_t     state_q, state_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] len_q, len_d;
    logic [7:0] sum_q, sum_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] cfg_addr_q, cfg_addr_d;
    logic [2:0] code_q, code_d;
    logic       ready_q, we_q, we_d, done_q, done_d, err_q, err_d;
    logic       accept, timeout_hit;

    logic          buf_we;
    logic [IW-1:0] buf_waddr, buf_raddr;
    logic [7:0]    buf_rdata;

    assign accept = in_valid && ready_q;

    assign buf_we    = accept && (state_q == DATA);
    assign buf_waddr = cnt_q[IW-1:0];
    // Registered read: fetch the entry for the next replay cycle one cycle early.
    assign buf_raddr = (state_q == REPLAY) ? cnt_q[IW-1:0] + IW'(1) : '0;

    loader_frame_buf #(
        .MAX_LEN(MAX_LEN)
    ) u_buf (
        .clk  (cfg_clk),
        .we   (buf_we),
        .waddr(buf_waddr),
        .wdata(in_data),
        .raddr(buf_raddr),
        .rdata(buf_rdata)
    );

`ifdef ADDR_DECODER_CFG_LOADER_TIMEOUT_EN
    localparam int unsigned    TW       = $clog2(TIMEOUT_CYC + 1);
    // err is registered, so fire one count early to land TIMEOUT_CYC cycles after the last byte.
    localparam logic [TW-1:0]  TMO_FIRE = TW'(TIMEOUT_CYC - 2);

    logic [TW-1:0] tmo_q;
    logic          in_frame;

    assign in_frame = state_q inside {ADDR, LEN, DATA, CHK};

    always_ff @(posedge cfg_clk) begin
        if (rst || !in_frame || accept || (state_d != state_q)) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + 1'b1;
        end
    end

    assign timeout_hit = in_frame && !accept && (tmo_q == TMO_FIRE);
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYC != 0);
    assign timeout_hit    = 1'b0;
`endif

    always_ff @(posedge cfg_clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        sum_d      = sum_q;
        cnt_d      = cnt_q;
        cfg_addr_d = cfg_addr_q;
        code_d     = code_q;
        we_d       = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept && (in_data == SYNC_BYTE)) begin
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (accept) begin
                    addr_d  = in_data;
                    sum_d   = in_data;
                    state_d = LEN;
                end
            end
            LEN: begin
                if (accept) begin
                    len_d = in_data;
                    sum_d = sum_q + in_data;
                    cnt_d = 8'd0;
                    if ((in_data == 8'd0) || (in_data > LEN_MAX)) begin
                        err_d   = 1'b1;
                        code_d  = ERR_LEN;
                        state_d = IDLE;
                    end else if (({1'b0, addr_q} + {1'b0, in_data}) > CFG_LIM) begin
                        err_d   = 1'b1;
                        code_d  = ERR_RANGE;
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    sum_d = sum_q + in_data;
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == len_q - 8'd1) begin
                        state_d = CHK;
                    end
                end
            end
            CHK: begin
                if (accept) begin
                    if (in_data == sum_q) begin
                        state_d    = REPLAY;
                        cnt_d      = 8'd0;
                        we_d       = 1'b1;
                        cfg_addr_d = addr_q;
                    end else begin
                        err_d   = 1'b1;
                        code_d  = ERR_CHK;
                        state_d = IDLE;
                    end
                end
            end
            REPLAY: begin
                // cnt_q is the index of the write currently on the outputs.
                if (cnt_q == len_q - 8'd1) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d      = cnt_q + 8'd1;
                    we_d       = 1'b1;
                    cfg_addr_d = cfg_addr_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (timeout_hit) begin
            err_d   = 1'b1;
            code_d  = ERR_TIMEOUT;
            state_d = IDLE;
        end
    end

    always_ff @(posedge cfg_clk) begin
        if (rst) begin
            addr_q     <= 8'd0;
            len_q      <= 8'd0;
            sum_q      <= 8'd0;
            cnt_q      <= 8'd0;
            cfg_addr_q <= 8'd0;
            code_q     <= ERR_NONE;
            ready_q    <= 1'b0;
            we_q       <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            len_q      <= len_d;
            sum_q      <= sum_d;
            cnt_q      <= cnt_d;
            cfg_addr_q <= cfg_addr_d;
            code_q     <= code_d;
            ready_q    <= (state_d != REPLAY);
            we_q       <= we_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign in_ready  = ready_q;
    assign cfg_we    = we_q;
    assign cfg_addr  = cfg_addr_q;
    assign cfg_wdata = we_q ? buf_rdata : 8'h00;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign err       = err_q;
    assign err_code  = code_q;

endmodule

// File: tb/tb_addr_decoder_cfg_loader.sv
// tb/tb_addr_decoder_cfg_loader.sv - randomized self-checking bench for addr_decoder_cfg_loader
module tb_addr_decoder_cfg_loader;

    logic       cfg_clk, rst, in_valid, in_ready;
    logic [7:0] in_data, cfg_addr, cfg_wdata;
    logic       cfg_we, busy, done, err;
    logic [2:0] err_code;

    int checks = 0;
    int passed = 0;
    int cyc = 0;

    logic [15:0] wr_q[$];
    int wr_cyc[$];
    int done_cyc[$];
    int err_cyc[$];
    int err_code_q[$];
    int rdy_low = 0;
    int both_hi = 0;
    int busy_at_done = 0;
    int busy_at_err = 0;

    addr_decoder_cfg_loader #(
        .MAX_LEN(32),
        .CFG_SIZE(160),
        .TIMEOUT_CYC(16)
    ) dut (
        .cfg_clk  (cfg_clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_wdata(cfg_wdata),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .err_code (err_code)
    );

    initial cfg_clk = 1'b0;
    always #5 cfg_clk = ~cfg_clk;
    always @(posedge cfg_clk) cyc <= cyc + 1;

    always @(negedge cfg_clk) begin
        if (cfg_we) begin
            wr_q.push_back({cfg_addr, cfg_wdata});
            wr_cyc.push_back(cyc);
        end
        if (done) done_cyc.push_back(cyc);
        if (err) begin
            err_cyc.push_back(cyc);
            err_code_q.push_back(int'(err_code));
        end
        if (!in_ready && !rst) rdy_low++;
        if (err && done) both_hi++;
        if (done && busy) busy_at_done++;
        if (err && busy) busy_at_err++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] frame_sum(input logic [7:0] a, input logic [7:0] l, input logic [7:0] p[$]);
        int s;
        s = int'(a) + int'(l);
        foreach (p[i]) s += int'(p[i]);
        return 8'(s % 256);
    endfunction

    function automatic int model_code(input logic [7:0] a, input logic [7:0] l, input logic [7:0] p[$], input logic [7:0] c);
        if (l == 8'd0 || int'(l) > 32) return 1;
        if (int'(a) + int'(l) > 160) return 2;
        if (frame_sum(a, l, p) != c) return 3;
        return 0;
    endfunction

    task automatic clear_mon();
        wr_q.delete(); wr_cyc.delete(); done_cyc.delete();
        err_cyc.delete(); err_code_q.delete();
        rdy_low = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap, output int edge_n);
        int gap, budget;
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        in_valid = 1'b0;
        repeat (gap) @(negedge cfg_clk);
        in_valid = 1'b1;
        in_data  = b;
        budget   = 200;
        edge_n   = -1;
        while (edge_n < 0 && budget > 0) begin
            if (in_ready) edge_n = cyc + 1;
            @(negedge cfg_clk);
            budget--;
        end
        in_valid = 1'b0;
        checks++;
        if (edge_n < 0) $display("FAIL byte_accept: byte %h not accepted within 200 cycles", b);
        else passed++;
    endtask

    task automatic send_frame(input logic [7:0] fb[$], input int max_gap, output int last_edge);
        last_edge = -1;
        foreach (fb[i]) send_byte(fb[i], max_gap, last_edge);
    endtask

    task automatic test_reset();
        logic [22:0] outs;
        rst = 1'b1; in_valid = 1'b1; in_data = 8'hA5;
        repeat (3) @(negedge cfg_clk);
        outs = {cfg_we, cfg_addr, cfg_wdata, busy, done, err, err_code};
        checks++;
        if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %b required 0", in_ready); else passed++;
        checks++;
        if (outs !== 23'd0) $display("FAIL reset_outputs got %h required 0", outs); else passed++;
        rst = 1'b0; in_valid = 1'b0;
        @(negedge cfg_clk);
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) $display("FAIL reset_release ready=%b busy=%b required 1/0", in_ready, busy);
        else passed++;
    endtask

    task automatic test_good_frame();
        logic [7:0] p[$];
        logic [7:0] fb[$];
        int e;
        p  = {8'h11, 8'h22, 8'h33};
        fb = {8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, frame_sum(8'h10, 8'h03, p)};
        clear_mon();
        send_frame(fb, 0, e);
        repeat (5) @(negedge cfg_clk);
        checks++;
        if (wr_q.size() != 3 || wr_q[0] !== 16'h1011 || wr_q[1] !== 16'h1122 || wr_q[2] !== 16'h1233)
            $display("FAIL good_writes got n=%0d first=%h required n=3 1011,1122,1233", wr_q.size(), wr_q.size() ? wr_q[0] : 16'h0);
        else passed++;
        checks++;
        if (wr_cyc.size() != 3 || wr_cyc[0] != e || wr_cyc[2] != e + 2)
            $display("FAIL good_write_timing got first=%0d required %0d", wr_cyc.size() ? wr_cyc[0] : -1, e);
        else passed++;
        checks++;
        if (done_cyc.size() != 1 || done_cyc[0] != e + 3 || err_cyc.size() != 0)
            $display("FAIL good_done got n=%0d cyc=%0d errs=%0d required 1 at %0d, 0 errs",
                     done_cyc.size(), done_cyc.size() ? done_cyc[0] : -1, err_cyc.size(), e + 3);
        else passed++;
    endtask

    task automatic test_bad_chk();
        logic [7:0] p[$];
        logic [7:0] fb[$];
        int e;
        fb = {8'hA5, 8'h00, 8'h02, 8'hAA, 8'hBB, 8'h00};
        clear_mon();
        send_frame(fb, 1, e);
        repeat (4) @(negedge cfg_clk);
        checks++;
        if (wr_q.size() != 0 || err_cyc.size() != 1 || err_code_q[0] != 3 || err_cyc[0] != e)
            $display("FAIL bad_chk got writes=%0d errs=%0d code=%0d required 0 writes, err code 3 at %0d",
                     wr_q.size(), err_cyc.size(), err_code_q.size() ? err_code_q[0] : -1, e);
        else passed++;
        checks++;
        if (err_code !== 3'd3) $display("FAIL bad_chk_hold got %0d required 3", err_code); else passed++;
        p  = {8'h5C, 8'hE1};
        fb = {8'hA5, 8'h40, 8'h02, 8'h5C, 8'hE1, frame_sum(8'h40, 8'h02, p)};
        clear_mon();
        send_frame(fb, 1, e);
        repeat (4) @(negedge cfg_clk);
        checks++;
        if (wr_q.size() != 2 || wr_q[0] !== 16'h405C || wr_q[1] !== 16'h41E1 || done_cyc.size() != 1)
            $display("FAIL after_bad_commit got writes=%0d done=%0d required 2 writes 405C,41E1 and done", wr_q.size(), done_cyc.size());
        else passed++;
    endtask

    task automatic test_len_range();
        logic [7:0] tbl_a[4] = '{8'h05, 8'h9F, 8'h00, 8'hFF};
        logic [7:0] tbl_l[4] = '{8'h00, 8'h02, 8'h21, 8'h01};
        int         tbl_c[4] = '{1, 2, 1, 2};
        logic [7:0] fb[$];
        logic [7:0] p[$];
        int e, ej;
        for (int k = 0; k < 4; k++) begin
            fb = {8'hA5, tbl_a[k], tbl_l[k]};
            clear_mon();
            send_frame(fb, 0, e);
            send_byte(8'h11, 0, ej);
            send_byte(8'h22, 0, ej);
            repeat (2) @(negedge cfg_clk);
            checks++;
            if (err_cyc.size() != 1 || err_code_q[0] != tbl_c[k] || err_cyc[0] != e || wr_q.size() != 0 ||
                rdy_low != 0 || busy !== 1'b0)
                $display("FAIL len_range[%0d] got errs=%0d code=%0d writes=%0d ready_low=%0d busy=%b required code %0d at %0d",
                         k, err_cyc.size(), err_code_q.size() ? err_code_q[0] : -1, wr_q.size(), rdy_low, busy, tbl_c[k], e);
            else passed++;
        end
        p  = {8'h01, 8'h02};
        fb = {8'hA5, 8'h9E, 8'h02, 8'h01, 8'h02, frame_sum(8'h9E, 8'h02, p)};
        clear_mon();
        send_frame(fb, 0, e);
        repeat (4) @(negedge cfg_clk);
        checks++;
        if (wr_q.size() != 2 || wr_q[1] !== 16'h9F02 || err_cyc.size() != 0)
            $display("FAIL range_edge got writes=%0d errs=%0d required 2 writes ending 9F02", wr_q.size(), err_cyc.size());
        else passed++;
    endtask

    task automatic test_random_frames(input int n);
        for (int f = 0; f < n; f++) begin
            logic [7:0] a, l, c;
            logic [7:0] p[$];
            logic [7:0] fb[$];
            int kind, code, e, bad;
            kind = int'($urandom_range(9, 0));
            if (kind == 0) begin
                l = $urandom_range(1, 0) ? 8'd0 : 8'($urandom_range(255, 33));
                a = 8'($urandom);
            end else if (kind == 1) begin
                l = 8'($urandom_range(32, 1));
                a = 8'($urandom_range(255, 161 - int'(l)));
            end else begin
                l = 8'($urandom_range(32, 1));
                a = 8'($urandom_range(160 - int'(l), 0));
            end
            p.delete();
            for (int i = 0; i < int'(l); i++) p.push_back(8'($urandom));
            c = frame_sum(a, l, p);
            if (kind == 2) c = c ^ 8'($urandom_range(255, 1));
            code = model_code(a, l, p, c);
            fb = {8'hA5, a, l};
            if (code == 0 || code == 3) begin
                foreach (p[i]) fb.push_back(p[i]);
                fb.push_back(c);
            end
            clear_mon();
            send_frame(fb, 2, e);
            repeat ((code == 0) ? int'(l) + 3 : 3) @(negedge cfg_clk);
            if (code == 0) begin
                bad = (wr_q.size() != int'(l)) ? 1 : 0;
                for (int i = 0; i < wr_q.size() && i < int'(l); i++)
                    if (wr_q[i] !== {8'(a + 8'(i)), p[i]}) bad++;
                checks++;
                if (bad != 0) $display("FAIL rand_commit[%0d] got %0d writes (%0d wrong) required %0d from addr %h", f, wr_q.size(), bad, l, a);
                else passed++;
                checks++;
                if (wr_cyc.size() == 0 || wr_cyc[0] != e || done_cyc.size() != 1 || done_cyc[0] != e + int'(l) ||
                    err_cyc.size() != 0 || rdy_low != int'(l))
                    $display("FAIL rand_timing[%0d] got first=%0d done=%0d ready_low=%0d required %0d/%0d/%0d",
                             f, wr_cyc.size() ? wr_cyc[0] : -1, done_cyc.size() ? done_cyc[0] : -1, rdy_low, e, e + int'(l), l);
                else passed++;
            end else begin
                checks++;
                if (wr_q.size() != 0 || err_cyc.size() != 1 || err_code_q[0] != code || err_cyc[0] != e || err_code !== 3'(code))
                    $display("FAIL rand_reject[%0d] got writes=%0d errs=%0d code=%0d required code %0d at %0d",
                             f, wr_q.size(), err_cyc.size(), err_code_q.size() ? err_code_q[0] : -1, code, e);
                else passed++;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] a;
        logic [7:0] p[$];
        logic [7:0] fb[$];
        int e, e2, bad;
        a = 8'($urandom_range(128, 0));
        for (int i = 0; i < 32; i++) p.push_back(8'($urandom));
        fb = {8'hA5, a, 8'd32};
        foreach (p[i]) fb.push_back(p[i]);
        fb.push_back(frame_sum(a, 8'd32, p));
        clear_mon();
        send_frame(fb, 4, e);
        send_byte(8'hA5, 0, e2);
        checks++;
        if (rdy_low != 32 || e2 != e + 33 || done_cyc.size() != 1 || done_cyc[0] != e + 32)
            $display("FAIL replay_backpressure got ready_low=%0d sync_edge=%0d done=%0d required 32/%0d/%0d",
                     rdy_low, e2, done_cyc.size() ? done_cyc[0] : -1, e + 33, e + 32);
        else passed++;
        bad = (wr_q.size() != 32) ? 1 : 0;
        for (int i = 0; i < wr_q.size() && i < 32; i++)
            if (wr_q[i] !== {8'(a + 8'(i)), p[i]}) bad++;
        checks++;
        if (bad != 0) $display("FAIL gap_commit got %0d writes (%0d wrong) required 32 from addr %h", wr_q.size(), bad, a);
        else passed++;
        p  = {8'h77};
        fb = {8'h03, 8'h01, 8'h77, frame_sum(8'h03, 8'h01, p)};
        send_frame(fb, 0, e);
        repeat (3) @(negedge cfg_clk);
        checks++;
        if (wr_q.size() != 33 || wr_q[32] !== 16'h0377 || done_cyc.size() != 2)
            $display("FAIL b2b_second got writes=%0d done=%0d required 33 writes ending 0377 and 2 done", wr_q.size(), done_cyc.size());
        else passed++;
    endtask

    task automatic test_reset_replay();
        logic [7:0] p[$];
        logic [7:0] fb[$];
        logic [22:0] outs;
        int e;
        p  = {8'hD1, 8'hD2, 8'hD3, 8'hD4};
        fb = {8'hA5, 8'h30, 8'h04, 8'hD1, 8'hD2, 8'hD3, 8'hD4, frame_sum(8'h30, 8'h04, p)};
        clear_mon();
        send_frame(fb, 0, e);
        @(negedge cfg_clk);
        rst = 1'b1;
        @(negedge cfg_clk);
        outs = {cfg_we, cfg_addr, cfg_wdata, busy, done, err, err_code};
        checks++;
        if (outs !== 23'd0 || in_ready !== 1'b0)
            $display("FAIL reset_replay_outputs got %h ready=%b required 0/0", outs, in_ready);
        else passed++;
        @(negedge cfg_clk);
        rst = 1'b0;
        repeat (6) @(negedge cfg_clk);
        checks++;
        if (wr_q.size() != 2 || wr_q[0] !== 16'h30D1 || wr_q[1] !== 16'h31D2 || done_cyc.size() != 0)
            $display("FAIL reset_replay_stop got writes=%0d done=%0d required 2 writes, no done", wr_q.size(), done_cyc.size());
        else passed++;
        clear_mon();
        send_frame(fb, 1, e);
        repeat (6) @(negedge cfg_clk);
        checks++;
        if (wr_q.size() != 4 || wr_q[3] !== 16'h33D4 || done_cyc.size() != 1)
            $display("FAIL reset_replay_fresh got writes=%0d done=%0d required 4 writes ending 33D4", wr_q.size(), done_cyc.size());
        else passed++;
    endtask

`ifdef ADDR_DECODER_CFG_LOADER_TIMEOUT_EN
    task automatic test_timeout();
        logic [7:0] fb[$];
        int e;
        fb = {8'hA5, 8'h20};
        clear_mon();
        busy_at_err = 0;
        send_frame(fb, 0, e);
        repeat (24) @(negedge cfg_clk);
        checks++;
        if (err_cyc.size() != 1 || err_cyc[0] != e + 15 || err_code_q[0] != 4 || busy_at_err != 0)
            $display("FAIL timeout got errs=%0d cyc=%0d code=%0d busy_at_err=%0d required 1 at %0d code 4",
                     err_cyc.size(), err_cyc.size() ? err_cyc[0] : -1, err_code_q.size() ? err_code_q[0] : -1, busy_at_err, e + 15);
        else passed++;
    endtask
`endif

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
        test_reset();
        test_good_frame();
        test_bad_chk();
        test_len_range();
        test_random_frames(24);
        test_back_to_back();
        test_reset_replay();
`ifdef ADDR_DECODER_CFG_LOADER_TIMEOUT_EN
        test_timeout();
`endif
        checks++;
        if (both_hi != 0 || busy_at_done != 0)
            $display("FAIL pulse_exclusive got err&done=%0d busy_at_done=%0d required 0/0", both_hi, busy_at_done);
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
